// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, state encoding and buffer entry type for fetch_unit
package fetch_pkg;

  localparam int INSTR_W      = 32;
  localparam int PC_STEP      = 4;
  localparam int DEFAULT_PC_W = 10;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0]      instr;
    logic [DEFAULT_PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - synchronous FIFO holding fetched {instr, pc} entries
// Pointers carry one extra MSB so full and empty are distinguishable.
module fetch_buffer #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 42
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Push into a full buffer only happens alongside a pop, so overwriting the head slot is safe.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC generation, imem requests, buffered hand-off
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter int              PC_W      = 10,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic            misalign_err
);

  import fetch_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  fetch_state_e    state, state_nxt;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            pop, push, flush, issue;
  entry_t          din, dout;

  assign pop = instr_valid & instr_ready;
  // Slots committed after this edge: buffered plus in flight, less what leaves now.
  assign occ = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |redirect_pc[1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    flush     = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (redirect) begin
          flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (misaligned) state_nxt = ERR;
`endif
        end else begin
          issue = (occ < (CW+1)'(BUF_DEPTH));
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      ERR: begin
        if (redirect) begin
          flush = 1'b1;
          if (!misaligned) state_nxt = RUN;
        end
      end
`endif
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (flush) begin
      fetch_pc <= redirect_pc & ~PC_W'(3);
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc    <= fetch_pc + PC_W'(PC_STEP);
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else if (imem_rvalid) begin
      inflight <= 1'b0;
    end
  end

  assign push      = imem_rvalid & inflight & ~flush;
  assign din.instr = imem_rdata;
  assign din.pc    = inflight_pc;

  fetch_buffer #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W ($bits(entry_t))
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (count)
  );

  assign imem_req    = rst_n & issue;
  assign imem_addr   = fetch_pc;
  assign instr_valid = rst_n & (count != '0);
  assign instr       = dout.instr;
  assign instr_pc    = dout.pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_err = rst_n & (state == ERR);
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a 1-cycle imem model
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int PC_W      = 10;
  localparam int BUF_DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [PC_W-1:0] instr_pc;
  logic            misalign_err;

  fetch_unit #(
    .PC_W      (PC_W),
    .RESET_PC  ('0),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int first_valid_cyc, first_req_cyc, max_occ, req_count;

  fetch_entry_t    sb[$];
  logic [PC_W-1:0] reqs[$];
  logic [PC_W-1:0] popped[$];

  fetch_state_e    m_state = BOOT;
  logic [PC_W-1:0] exp_pc = '0;
  logic [PC_W-1:0] m_inpc = '0;
  logic            m_inflight = 1'b0;

  function automatic logic [31:0] word_of(input logic [PC_W-1:0] a);
    return {12'hC0D, ~a, a};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic            req_s, pop_s, push_s;
    logic [PC_W-1:0] addr_s;
    fetch_entry_t    e;
    @(negedge clk);
    req_s  = imem_req;
    addr_s = imem_addr;
    pop_s  = instr_valid && instr_ready;
    if (!rst_n) begin
      check_eq("rst_imem_req", imem_req, 0);
      check_eq("rst_instr_valid", instr_valid, 0);
      check_eq("rst_misalign_err", misalign_err, 0);
      m_state = BOOT; exp_pc = '0; m_inflight = 1'b0; sb.delete();
    end else begin
      check_eq("valid_vs_model", instr_valid, sb.size() != 0);
      check_eq("misalign_err", misalign_err, m_state == ERR);
      if (instr_valid && sb.size() != 0) begin
        check_eq("head_pc", instr_pc, sb[0].pc);
        check_eq("head_instr", instr, sb[0].instr);
      end
      if (req_s) begin
        check_eq("req_allowed", (m_state == RUN) && !redirect, 1);
        check_eq("imem_addr", addr_s, exp_pc);
        reqs.push_back(addr_s);
        req_count++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pop_s) begin
        popped.push_back(instr_pc);
        if (sb.size() != 0) void'(sb.pop_front());
      end
      push_s = imem_rvalid && m_inflight && !(redirect && m_state != BOOT);
      if (push_s) begin
        check_eq("push_room", sb.size() < BUF_DEPTH, 1);
        e.instr = word_of(m_inpc);
        e.pc    = m_inpc;
        sb.push_back(e);
      end
      if (m_state == BOOT) begin
        m_state = RUN;
      end else if (redirect) begin
        sb.delete();
        m_inflight = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_pc[1:0] != 2'b00) begin
          m_state = ERR;
        end else begin
          m_state = RUN;
          exp_pc  = {redirect_pc[PC_W-1:2], 2'b00};
        end
`else
        exp_pc = {redirect_pc[PC_W-1:2], 2'b00};
`endif
      end else if (m_state == RUN) begin
        if (req_s) begin
          m_inflight = 1'b1;
          m_inpc     = exp_pc;
          exp_pc     = exp_pc + 10'd4;
        end else if (imem_rvalid) begin
          m_inflight = 1'b0;
        end
      end
      if (sb.size() + int'(m_inflight) > max_occ) max_occ = sb.size() + int'(m_inflight);
    end
    @(posedge clk);
    #1;
    imem_rvalid = req_s;
    imem_rdata  = word_of(addr_s);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    cyc = 0; first_valid_cyc = -1; first_req_cyc = -1; req_count = 0; max_occ = 0;
    reqs.delete();
    popped.delete();
  endtask

  task automatic pulse_redirect(input logic [PC_W-1:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step();
    redirect = 1'b0;
  endtask

  function automatic int count_pc(input logic [PC_W-1:0] pc);
    int n = 0;
    foreach (popped[i]) if (popped[i] == pc) n++;
    return n;
  endfunction

  initial begin
    int  found;
    logic wrap_r, wrap_p;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b1;

    // Streaming after reset: latency and throughput
    do_reset();
    repeat (12) step();
    check_eq("first_req_cycle", first_req_cyc, 1);
    check_eq("first_valid_cycle", first_valid_cyc, 3);
    check_eq("req_count_stream", req_count, 11);
    check_eq("pop_count_stream", popped.size(), 9);

    // Consumer stalls for 10 cycles
    do_reset();
    for (int i = 0; i < 10 && !instr_valid; i++) step();
    check_eq("hold_first_valid", instr_valid, 1);
    instr_ready = 1'b0;
    max_occ = 0;
    repeat (10) step();
    check_eq("hold_max_occ", max_occ, BUF_DEPTH);
    check_eq("hold_valid", instr_valid, 1);
    check_eq("hold_pc", instr_pc, 0);
    popped.delete();
    instr_ready = 1'b1;
    repeat (6) step();
    check_eq("release_count", popped.size() >= 3, 1);
    check_eq("release_pc0", popped[0], 10'h000);
    check_eq("release_pc1", popped[1], 10'h004);
    check_eq("release_pc2", popped[2], 10'h008);

    // Redirect while the response for 0x010 is in flight
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (reqs.size() != 0 && reqs[$] == 10'h010) found = 1;
    end
    check_eq("saw_req_010", found, 1);
    pulse_redirect(10'h100);
    popped.delete();
    reqs.delete();
    repeat (6) step();
    check_eq("redir_next_addr", reqs.size() != 0 ? reqs[0] : 10'h3FF, 10'h100);
    check_eq("redir_next_pc", popped.size() != 0 ? popped[0] : 10'h3FF, 10'h100);
    check_eq("pc010_dropped", count_pc(10'h010), 0);

    // Redirect in the same cycle as a pop of 0x008
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (instr_valid && instr_pc == 10'h008) found = 1;
    end
    check_eq("saw_head_008", found, 1);
    popped.delete();
    pulse_redirect(10'h040);
    repeat (6) step();
    check_eq("pc008_once", count_pc(10'h008), 1);
    check_eq("pop_redirect_next", popped.size() >= 2 ? popped[1] : 10'h3FF, 10'h040);

    // PC wrap at the top of the address space
    reqs.delete();
    pulse_redirect(10'h3F0);
    popped.delete();
    repeat (10) step();
    wrap_r = 1'b0;
    wrap_p = 1'b0;
    for (int i = 0; i + 1 < reqs.size(); i++)
      if (reqs[i] == 10'h3FC && reqs[i+1] == 10'h000) wrap_r = 1'b1;
    for (int i = 0; i + 1 < popped.size(); i++)
      if (popped[i] == 10'h3FC && popped[i+1] == 10'h000) wrap_p = 1'b1;
    check_eq("wrap_req", wrap_r, 1);
    check_eq("wrap_instr", wrap_p, 1);

    // Misaligned redirect target
    pulse_redirect(10'h102);
    reqs.delete();
    popped.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
    repeat (5) step();
    check_eq("err_sticky", misalign_err, 1);
    check_eq("err_no_req", reqs.size(), 0);
    pulse_redirect(10'h200);
    check_eq("err_cleared", misalign_err, 0);
    popped.delete();
    repeat (5) step();
    check_eq("err_resume_addr", reqs.size() != 0 ? reqs[0] : 10'h3FF, 10'h200);
    check_eq("err_resume_pc", popped.size() != 0 ? popped[0] : 10'h3FF, 10'h200);
`else
    check_eq("misalign_low", misalign_err, 0);
    repeat (5) step();
    check_eq("misalign_addr", reqs.size() != 0 ? reqs[0] : 10'h3FF, 10'h100);
    check_eq("misalign_pc", popped.size() != 0 ? popped[0] : 10'h3FF, 10'h100);
`endif

    // Reset in the middle of streaming
    repeat (3) step();
    do_reset();
    repeat (6) step();
    check_eq("rereset_first_valid", first_valid_cyc, 3);
    check_eq("rereset_pc0", popped.size() != 0 ? popped[0] : 10'h3FF, 10'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
